// File: rtl/proc_trace_buffer_if.sv
// Bundle of the processor debug taps, the arm/read controls and the trace read-back port.
// The bench or debug path drives it through master; the trace buffer uses slave.
interface proc_trace_buffer_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [15:0]      IR_Out;
    logic [7:0]       PC_Out;
    logic [3:0]       State;
    logic [15:0]      ALU_Out;
    logic             Arm;
    logic             Rd_Req;
    logic             Rd_Valid;
    logic [43:0]      Rd_Data;
    logic [CNT_W-1:0] Count;
    logic             Frozen;
    logic             Overflow;

    modport master (
        output IR_Out, PC_Out, State, ALU_Out, Arm, Rd_Req,
        input  Rd_Valid, Rd_Data, Count, Frozen, Overflow
    );

    modport slave (
        input  IR_Out, PC_Out, State, ALU_Out, Arm, Rd_Req,
        output Rd_Valid, Rd_Data, Count, Frozen, Overflow
    );
endinterface

// File: rtl/proc_trace_buffer.sv
// Circular trace of processor FSM state changes. Capture freezes on HALT, and the
// history is then drained oldest-first through a registered one-cycle read port.
module proc_trace_buffer #(
    parameter int         DEPTH      = 16,
    parameter logic [3:0] HALT_STATE = 4'd9
) (
    input  logic                 clk,
    input  logic                 Reset,
    proc_trace_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {CAPTURE = 1'b0, FROZEN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [3:0]       prev_state;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             rd_valid;
    logic [43:0]      rd_data;
    logic [43:0]      mem [DEPTH];

    logic             capture, read, full;
    logic [43:0]      entry;

    assign full  = (count == CNT_W'(DEPTH));
    assign entry = {bus.PC_Out, bus.IR_Out, bus.State, bus.ALU_Out};

    always_ff @(posedge clk) begin
        if (Reset) state_q <= CAPTURE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.Arm)
            state_d = CAPTURE;
        else if (capture && bus.State == HALT_STATE)
            state_d = FROZEN;
    end

    // Arm outranks both capture and read, so it gates them here once.
    always_comb begin
        capture = 1'b0;
        read    = 1'b0;
        if (state_q == CAPTURE)
            capture = (bus.State != prev_state) && !bus.Arm;
        else
            read = bus.Rd_Req && (count != '0) && !bus.Arm;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            prev_state <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else if (bus.Arm) begin
            prev_state <= bus.State;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            prev_state <= bus.State;
            rd_valid   <= read;
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (read) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
                count   <= count - CNT_W'(1);
            end
        end
    end

    // Storage is never cleared; Count and the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (capture && !Reset)
            mem[wr_ptr] <= entry;
    end

    assign bus.Rd_Valid = rd_valid;
    assign bus.Rd_Data  = rd_data;
    assign bus.Count    = count;
    assign bus.Frozen   = (state_q == FROZEN);
    assign bus.Overflow = overflow;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed bench for proc_trace_buffer with hand-derived expected trace entries.
module tb_proc_trace_buffer;
    logic clk = 1'b0;
    logic Reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    proc_trace_buffer_if #(.DEPTH(16)) bus ();

    proc_trace_buffer #(.DEPTH(16), .HALT_STATE(4'd9)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] ent(input logic [7:0] pc, input logic [15:0] ir,
                                        input logic [3:0] st, input logic [15:0] alu);
        return {pc, ir, st, alu};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic change(input logic [3:0] st, input logic [7:0] pc,
                          input logic [15:0] ir, input logic [15:0] alu);
        bus.State   = st;
        bus.PC_Out  = pc;
        bus.IR_Out  = ir;
        bus.ALU_Out = alu;
        step();
    endtask

    task automatic arm();
        bus.Arm = 1'b1;
        step();
        bus.Arm = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        bus.State   = '0;
        bus.PC_Out  = '0;
        bus.IR_Out  = '0;
        bus.ALU_Out = '0;
        bus.Arm     = 1'b0;
        bus.Rd_Req  = 1'b0;
        step();
        step();
        Reset = 1'b0;

        chk("rst_count",    64'(bus.Count),    64'd0);
        chk("rst_frozen",   64'(bus.Frozen),   64'd0);
        chk("rst_valid",    64'(bus.Rd_Valid), 64'd0);
        chk("rst_overflow", 64'(bus.Overflow), 64'd0);
        chk("rst_data",     64'(bus.Rd_Data),  64'd0);

        // Basic sequence 1,2,3 then HALT, drained in order.
        change(4'd1, 8'h05, 16'h1234, 16'h0007);
        change(4'd2, 8'h05, 16'h1234, 16'h0007);
        change(4'd3, 8'h05, 16'h1234, 16'h0007);
        chk("seq_count3", 64'(bus.Count), 64'd3);
        chk("seq_frozen0", 64'(bus.Frozen), 64'd0);
        change(4'd9, 8'h05, 16'h1234, 16'h0007);
        chk("seq_count4", 64'(bus.Count), 64'd4);
        chk("seq_frozen1", 64'(bus.Frozen), 64'd1);
        bus.Rd_Req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] st;
            st = (i == 3) ? 4'd9 : 4'(i + 1);
            step();
            chk($sformatf("seq_rd_valid%0d", i), 64'(bus.Rd_Valid), 64'd1);
            chk($sformatf("seq_rd_data%0d", i), 64'(bus.Rd_Data),
                64'(ent(8'h05, 16'h1234, st, 16'h0007)));
        end
        step();
        chk("seq_empty_valid", 64'(bus.Rd_Valid), 64'd0);
        chk("seq_empty_hold",  64'(bus.Rd_Data),  64'(ent(8'h05, 16'h1234, 4'd9, 16'h0007)));
        chk("seq_empty_count", 64'(bus.Count),    64'd0);
        bus.Rd_Req = 1'b0;
        step();
        chk("seq_stay_frozen", 64'(bus.Frozen), 64'd1);

        // Overflow: 20 changes then HALT keeps changes 6..20 plus HALT.
        arm();
        chk("arm_frozen", 64'(bus.Frozen), 64'd0);
        for (int k = 1; k <= 20; k++)
            change((k % 2 == 1) ? 4'd1 : 4'd2, 8'(k), 16'h1000 + 16'(k), 16'h2000 + 16'(k));
        chk("ovf_count20", 64'(bus.Count),    64'd16);
        chk("ovf_flag",    64'(bus.Overflow), 64'd1);
        change(4'd9, 8'd21, 16'h1015, 16'h2015);
        chk("ovf_count_halt", 64'(bus.Count),  64'd16);
        chk("ovf_frozen",     64'(bus.Frozen), 64'd1);
        bus.Rd_Req = 1'b1;
        for (int k = 6; k <= 21; k++) begin
            logic [3:0] st;
            st = (k == 21) ? 4'd9 : ((k % 2 == 1) ? 4'd1 : 4'd2);
            step();
            chk($sformatf("ovf_rd%0d", k), {19'd0, bus.Rd_Valid, bus.Rd_Data},
                {19'd0, 1'b1, ent(8'(k), 16'h1000 + 16'(k), st, 16'h2000 + 16'(k))});
        end
        step();
        chk("ovf_after_valid", 64'(bus.Rd_Valid), 64'd0);
        bus.Rd_Req = 1'b0;

        // Held state is captured once; reads ignored while capturing.
        arm();
        for (int i = 0; i < 10; i++) change(4'd2, 8'h33, 16'h0bad, 16'h0001);
        chk("hold_count", 64'(bus.Count), 64'd1);
        bus.Rd_Req = 1'b1;
        step();
        chk("cap_rd_valid", 64'(bus.Rd_Valid), 64'd0);
        chk("cap_rd_count", 64'(bus.Count),    64'd1);
        bus.Rd_Req = 1'b0;

        // Arm and Rd_Req together while frozen with five entries.
        arm();
        change(4'd1, 8'h40, 16'h0001, 16'h0001);
        change(4'd2, 8'h41, 16'h0002, 16'h0002);
        change(4'd3, 8'h42, 16'h0003, 16'h0003);
        change(4'd4, 8'h43, 16'h0004, 16'h0004);
        change(4'd9, 8'h44, 16'h0005, 16'h0005);
        chk("armrd_count5", 64'(bus.Count),  64'd5);
        chk("armrd_frozen", 64'(bus.Frozen), 64'd1);
        bus.Arm    = 1'b1;
        bus.Rd_Req = 1'b1;
        step();
        bus.Arm    = 1'b0;
        bus.Rd_Req = 1'b0;
        chk("armrd_valid",    64'(bus.Rd_Valid), 64'd0);
        chk("armrd_count",    64'(bus.Count),    64'd0);
        chk("armrd_frozen0",  64'(bus.Frozen),   64'd0);
        chk("armrd_overflow", 64'(bus.Overflow), 64'd0);

        // Reset mid-capture wins over a pending change.
        for (int k = 1; k <= 7; k++)
            change((k % 2 == 1) ? 4'd1 : 4'd2, 8'(k), 16'h0, 16'h0);
        chk("mid_count7", 64'(bus.Count), 64'd7);
        Reset     = 1'b1;
        bus.State = 4'd3;
        step();
        Reset = 1'b0;
        chk("mid_rst_count",  64'(bus.Count),    64'd0);
        chk("mid_rst_frozen", 64'(bus.Frozen),   64'd0);
        chk("mid_rst_valid",  64'(bus.Rd_Valid), 64'd0);
        change(4'd4, 8'h77, 16'hbeef, 16'h00aa);
        chk("mid_first_count", 64'(bus.Count), 64'd1);
        change(4'd9, 8'h78, 16'hbef0, 16'h00ab);
        bus.Rd_Req = 1'b1;
        step();
        bus.Rd_Req = 1'b0;
        chk("mid_first_entry", {19'd0, bus.Rd_Valid, bus.Rd_Data},
            {19'd0, 1'b1, ent(8'h77, 16'hbeef, 4'd4, 16'h00aa)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_trace_buffer.md
# proc_trace_buffer

Trace capture unit that sits directly downstream of the processor and consumes its debug outputs (IR_Out, PC_Out, State, ALU_Out). It records one entry each time the processor FSM changes state into a circular buffer. It freezes automatically when the processor reaches HALT, and the captured history can then be drained oldest-first through a one-cycle request/valid read port. It lets the bench or a board-level debug path reconstruct the executed instruction sequence without probing the datapath.

## Interface
- DEPTH, 16: buffer entries; power of two, 2..256
- HALT_STATE, 9: FSM state code that triggers freeze
- clk  in  1  processor clock; all logic on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- IR_Out  in  16  processor instruction register
- PC_Out  in  8  processor program counter
- State  in  4  processor FSM current state
- ALU_Out  in  16  processor ALU output
- Arm  in  1  clears buffer and restarts capture
- Rd_Req  in  1  read request (honoured only when frozen)
- Rd_Valid  out  1  Rd_Data valid this cycle
- Rd_Data  out  44  {PC[43:36], IR[35:20], State[19:16], ALU[15:0]}
- Count  out  log2(DEPTH)+1  entries currently held
- Frozen  out  1  capture stopped, buffer readable
- Overflow  out  1  sticky: at least one entry overwritten since last Reset/Arm

## Operation
- Internal regs: Prev_State (4b), write pointer, read pointer, Count, 2-state FSM CAPTURE/FROZEN.
- Reset: FSM=CAPTURE, pointers=0, Count=0, Prev_State=0, Rd_Valid=0, Rd_Data=0, Frozen=0, Overflow=0. The memory array is not cleared.
- CAPTURE
  - Every edge: Prev_State <= State.
  - Capture condition: State != Prev_State. On that edge, write {PC_Out, IR_Out, State, ALU_Out} at the write pointer and advance the pointer modulo DEPTH.
  - If Count < DEPTH: Count+1. If Count == DEPTH: read pointer advances too (oldest entry overwritten), Count unchanged, Overflow <= 1.
  - Captured State == HALT_STATE: the entry is written and the FSM goes to FROZEN on the same edge.
  - Rd_Req is ignored; Rd_Valid stays 0.
- FROZEN
  - No capture; Prev_State keeps tracking State.
  - Rd_Req with Count>0: next edge drives Rd_Data = entry at read pointer, Rd_Valid=1, read pointer +1 mod DEPTH, Count-1.
  - Rd_Req with Count==0: Rd_Valid=0 and Rd_Data holds its last value.
  - Stays FROZEN after draining, until Arm or Reset.
- Arm, any state: pointers=0, Count=0, Overflow=0, Rd_Valid=0, FSM=CAPTURE, Prev_State <= State. The current State is therefore not captured on the Arm edge.
- Priority: Reset > Arm > capture/read. Arm and Rd_Req in the same cycle: the read is dropped.
- Reset while a processor state change is pending: reset wins. Prev_State=0, so a nonzero State on the first post-reset edge is captured.
- Frozen mirrors the FSM state. Count is saturating-free: it never exceeds DEPTH.

## Timing
- Capture latency: entry written on the edge where State first differs from Prev_State. Count and Frozen are updated on that same edge.
- Read latency: 1 cycle from Rd_Req to Rd_Valid. Rd_Valid is a single-cycle pulse per request.
- Back-to-back Rd_Req every cycle yields one entry per cycle, oldest first.
- Rd_Data is registered and holds between reads.
- Control outputs are registered; there is no combinational path from the processor inputs to any output.
- Processor states lasting one cycle each are all captured: one entry per edge is sustained.

## Test plan
- Reset, then State sequence 0→1→2→3 (one cycle each) with PC=0x05, IR=0x1234, ALU=0x0007 → Count=3. Freeze via State=9; Rd_Req ×4 returns four entries in order, the first with State=1, PC=0x05, IR=0x1234, ALU=7.
- 20 distinct state changes with DEPTH=16, then HALT → Overflow=1, Count=16. Draining returns the changes 6..20 plus HALT, oldest first; Rd_Req afterwards gives Rd_Valid=0.
- State held at 2 for 10 cycles → exactly one entry captured, Count=1.
- Rd_Req pulsed during CAPTURE → Rd_Valid stays 0, Count unchanged.
- Frozen with Count=5: assert Arm and Rd_Req in the same cycle → Rd_Valid=0 next cycle, Count=0, Frozen=0, Overflow=0.
- Reset asserted mid-capture with Count=7 → the next edge shows Count=0, Frozen=0, Rd_Valid=0; a subsequent State=4 is captured as the first entry.
